// File: rtl/cell_pos_reader_pkg.sv
// Shared constants, FSM state type and position-field helpers for the cell reader.
package cell_pos_reader_pkg;

   // Memory read latency; the in-flight pipe is sized from this.
   localparam int CPR_RD_LATENCY = 2;
   localparam int POS_W          = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_REQ,
      ST_HDR_WAIT,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } cpr_state_t;

   // Word layout is {posz, posy, posx}, posx in the low bits.
   function automatic logic [POS_W-1:0] pos_x(input logic [3*POS_W-1:0] w);
      return w[POS_W-1:0];
   endfunction

   function automatic logic [POS_W-1:0] pos_y(input logic [3*POS_W-1:0] w);
      return w[2*POS_W-1:POS_W];
   endfunction

   function automatic logic [POS_W-1:0] pos_z(input logic [3*POS_W-1:0] w);
      return w[3*POS_W-1:2*POS_W];
   endfunction

endpackage

// File: rtl/cell_pos_reader_if.sv
// Memory read bus plus particle output stream of the cell position reader.
interface cell_pos_reader_if #(
   parameter int DATA_WIDTH = 96,
   parameter int ADDR_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] mem_address;
   logic                  mem_rden;
   logic                  mem_wren;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [DATA_WIDTH-1:0] mem_q;

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0] out_index;
   logic                  out_last;

   // Reader side: drives the memory and sources the stream.
   modport master (
      output mem_address, mem_rden, mem_wren, mem_data,
      input  mem_q,
      output out_valid, out_data, out_index, out_last,
      input  out_ready
   );

   // Memory / consumer side.
   modport slave (
      input  mem_address, mem_rden, mem_wren, mem_data,
      output mem_q,
      input  out_valid, out_data, out_index, out_last,
      output out_ready
   );
endinterface

// File: rtl/cell_pos_fifo.sv
// Small synchronous FIFO; head entry is read straight from flops (no write-through).
module cell_pos_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0][WIDTH-1:0] store;
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic                        wr_ok, rd_ok;

   // Write at full is legal only alongside a read, which frees the head slot.
   assign rd_ok   = rd_en && !empty;
   assign wr_ok   = wr_en && (!full || rd_ok);
   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign rd_data = store[rd_ptr];

   // Storage, pointers and occupancy.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         store  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            store[wr_ptr] <= wr_data;
            wr_ptr        <= (wr_ptr == PW'(DEPTH-1)) ? '0 : wr_ptr + PW'(1);
         end
         if (rd_ok)
            rd_ptr <= (rd_ptr == PW'(DEPTH-1)) ? '0 : rd_ptr + PW'(1);
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/cell_pos_reader.sv
// Reads header + particle words from one cell memory and streams them out with
// credit-based flow control so no returning read is ever dropped.
module cell_pos_reader
   import cell_pos_reader_pkg::*;
#(
   parameter int DATA_WIDTH   = 96,
   parameter int ADDR_WIDTH   = 8,
   parameter int PARTICLE_NUM = 220,
   parameter int RD_LATENCY   = CPR_RD_LATENCY,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] cell_count,
   output logic                  err_overflow,
   cell_pos_reader_if.master     bus
);
   localparam int CW = $clog2(FIFO_DEPTH+1);
   localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] MAX_CNT = ADDR_WIDTH'(PARTICLE_NUM-1);

   cpr_state_t state, state_nxt;

   logic [ADDR_WIDTH-1:0] next_addr, addr_q, hdr_cnt;
   logic [RD_LATENCY:1]   vld_pipe, hdr_pipe, last_pipe;
   logic [RD_LATENCY:1][ADDR_WIDTH-1:0] idx_pipe;

   logic          issue_hdr, issue_pix, credit_ok, hdr_ret, pix_ret, drained;
   int            in_flight;
   logic          fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic [FW-1:0] fifo_wdata, fifo_rdata;
   logic [CW-1:0] fifo_count;

   assign hdr_cnt = bus.mem_q[ADDR_WIDTH-1:0];
   assign hdr_ret = (state == ST_HDR_WAIT) && vld_pipe[RD_LATENCY] && hdr_pipe[RD_LATENCY];
   assign pix_ret = vld_pipe[RD_LATENCY] && !hdr_pipe[RD_LATENCY];

   // Particle reads still travelling through the memory latency.
   always_comb begin
      in_flight = 0;
      for (int k = 1; k <= RD_LATENCY; k++)
         if (vld_pipe[k] && !hdr_pipe[k]) in_flight = in_flight + 1;
   end

   // Reserve a FIFO slot for every read before issuing it.
   assign credit_ok = !fifo_full && ((int'(fifo_count) + in_flight) < FIFO_DEPTH);

   // Finished once nothing is in flight and the final beat leaves this cycle.
   assign drained = (in_flight == 0) &&
                    (fifo_empty || (fifo_count == CW'(1) && fifo_rd));

   // State register.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:     if (start) state_nxt = ST_HDR_REQ;
         ST_HDR_REQ:  state_nxt = ST_HDR_WAIT;
         ST_HDR_WAIT: if (hdr_ret) state_nxt = (hdr_cnt == '0) ? ST_DONE : ST_STREAM;
         ST_STREAM:   if (issue_pix && next_addr == cell_count) state_nxt = ST_DRAIN;
         ST_DRAIN:    if (drained) state_nxt = ST_DONE;
         ST_DONE:     state_nxt = ST_IDLE;
         default:     state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs and memory request; address holds its last value between reads.
   always_comb begin
      busy            = (state != ST_IDLE);
      done            = (state == ST_DONE);
      issue_hdr       = (state == ST_HDR_REQ);
      issue_pix       = (state == ST_STREAM) && credit_ok;
      bus.mem_rden    = issue_hdr || issue_pix;
      bus.mem_address = addr_q;
      if (issue_hdr)      bus.mem_address = '0;
      else if (issue_pix) bus.mem_address = next_addr;
   end

   assign bus.mem_wren = 1'b0;
   assign bus.mem_data = '0;

   // In-flight pipe: one {valid, header, index, last} entry per issued read.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         hdr_pipe  <= '0;
         last_pipe <= '0;
         idx_pipe  <= '0;
      end else begin
         vld_pipe[1]  <= bus.mem_rden;
         hdr_pipe[1]  <= issue_hdr;
         idx_pipe[1]  <= next_addr;
         last_pipe[1] <= issue_pix && (next_addr == cell_count);
         for (int k = 2; k <= RD_LATENCY; k++) begin
            vld_pipe[k]  <= vld_pipe[k-1];
            hdr_pipe[k]  <= hdr_pipe[k-1];
            idx_pipe[k]  <= idx_pipe[k-1];
            last_pipe[k] <= last_pipe[k-1];
         end
      end
   end

   // Header latch with clamp, read address counter and overflow flag.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         addr_q       <= '0;
         next_addr    <= '0;
         cell_count   <= '0;
         err_overflow <= 1'b0;
      end else begin
         if (bus.mem_rden) addr_q <= bus.mem_address;
         if (state == ST_IDLE && start) err_overflow <= 1'b0;
         if (hdr_ret) begin
            if (hdr_cnt > MAX_CNT) begin
               cell_count   <= MAX_CNT;
               err_overflow <= 1'b1;
            end else begin
               cell_count <= hdr_cnt;
            end
            next_addr <= ADDR_WIDTH'(1);
         end else if (issue_pix) begin
            next_addr <= next_addr + ADDR_WIDTH'(1);
         end
      end
   end

   assign fifo_wr    = pix_ret;
   assign fifo_wdata = {last_pipe[RD_LATENCY], idx_pipe[RD_LATENCY], bus.mem_q};
   assign fifo_rd    = bus.out_valid && bus.out_ready;

   cell_pos_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock   (clock),
      .rst_n   (rst_n),
      .wr_en   (fifo_wr),
      .wr_data (fifo_wdata),
      .rd_en   (fifo_rd),
      .rd_data (fifo_rdata),
      .count   (fifo_count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   assign bus.out_valid = !fifo_empty;
   assign {bus.out_last, bus.out_index, bus.out_data} = fifo_rdata;
endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader with a 2-cycle-latency memory model.
module tb_cell_pos_reader;
   import cell_pos_reader_pkg::*;

   logic       clock = 1'b0;
   logic       rst_n;
   logic       start;
   logic       out_ready;
   logic       busy, done, err_overflow;
   logic [7:0] cell_count;

   cell_pos_reader_if #(.DATA_WIDTH(96), .ADDR_WIDTH(8)) bus ();

   cell_pos_reader #(
      .DATA_WIDTH(96), .ADDR_WIDTH(8), .PARTICLE_NUM(220), .RD_LATENCY(2), .FIFO_DEPTH(4)
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .start        (start),
      .busy         (busy),
      .done         (done),
      .cell_count   (cell_count),
      .err_overflow (err_overflow),
      .bus          (bus)
   );

   always #5 clock = ~clock;

   // Memory model: data appears two cycles after the rden cycle.
   logic [95:0] mem_arr [0:255];
   logic [95:0] m_s1, m_q;
   always @(posedge clock) begin
      m_s1 <= mem_arr[bus.mem_address];
      m_q  <= m_s1;
   end
   assign bus.mem_q     = m_q;
   assign bus.out_ready = out_ready;

   function automatic logic [95:0] word(input int i);
      logic [31:0] v;
      v = i[31:0];
      return {32'h3000_0000 + v, 32'h2000_0000 + v, 32'h1000_0000 + v};
   endfunction

   // Monitor: records reads, beats, done pulses, stall-hold violations, occupancy.
   int          cyc = 0;
   int          done_cnt = 0, done_cyc = 0, valid_cnt = 0, hold_err = 0;
   int          outstanding = 0, max_out = 0;
   logic        prev_stall = 1'b0;
   logic [95:0] p_data;
   logic [7:0]  p_idx;
   logic        p_last;
   logic [7:0]  rd_addr_q [$];
   int          rd_cyc_q [$];
   logic [7:0]  beat_idx_q [$];
   logic [95:0] beat_data_q [$];
   logic        beat_last_q [$];
   int          beat_cyc_q [$];

   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (!rst_n) begin
         outstanding <= 0;
         prev_stall  <= 1'b0;
      end else begin
         if (bus.mem_rden) begin
            rd_addr_q.push_back(bus.mem_address);
            rd_cyc_q.push_back(cyc);
         end
         if (bus.out_valid) valid_cnt <= valid_cnt + 1;
         if (prev_stall && !(bus.out_valid && bus.out_data === p_data &&
                             bus.out_index === p_idx && bus.out_last === p_last))
            hold_err <= hold_err + 1;
         if (bus.out_valid && out_ready) begin
            beat_idx_q.push_back(bus.out_index);
            beat_data_q.push_back(bus.out_data);
            beat_last_q.push_back(bus.out_last);
            beat_cyc_q.push_back(cyc);
         end
         outstanding <= outstanding
                        + ((bus.mem_rden && bus.mem_address != 8'd0) ? 1 : 0)
                        - ((bus.out_valid && out_ready) ? 1 : 0);
         if (outstanding > max_out) max_out <= outstanding;
         prev_stall <= bus.out_valid && !out_ready;
         p_data     <= bus.out_data;
         p_idx      <= bus.out_index;
         p_last     <= bus.out_last;
         if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
         end
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
   endtask

   // mode 0: ready held high; mode 1: ready one cycle on, three off.
   task automatic run_to_done(input int mode, input int budget, input string tag);
      bit seen = 0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(posedge clock); #1;
         out_ready = (mode == 0) ? 1'b1 : (k % 4 == 0);
         @(negedge clock);
         if (done) seen = 1;
      end
      chk({tag, "_done_seen"}, 128'(seen), 128'd1);
      out_ready = 1'b1;
   endtask

   task automatic settle();
      repeat (2) @(negedge clock);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int br, rr, dc, vc, e;
      bit found;
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 256; i++) mem_arr[i] = word(i);
      mem_arr[0] = 96'd0;

      // Reset state
      repeat (3) @(posedge clock); #1;
      chk("rst_busy",     128'(busy), 128'd0);
      chk("rst_done",     128'(done), 128'd0);
      chk("rst_valid",    128'(bus.out_valid), 128'd0);
      chk("rst_rden",     128'(bus.mem_rden), 128'd0);
      chk("rst_wren",     128'(bus.mem_wren), 128'd0);
      chk("rst_addr",     128'(bus.mem_address), 128'd0);
      chk("rst_count",    128'(cell_count), 128'd0);
      chk("rst_err",      128'(err_overflow), 128'd0);
      chk("rst_out_data", 128'(bus.out_data), 128'd0);
      rst_n = 1'b1;
      @(posedge clock); #1;

      // A: header=3, ready held
      mem_arr[0] = 96'd3;
      br = beat_idx_q.size(); rr = rd_addr_q.size(); dc = done_cnt;
      pulse_start();
      run_to_done(0, 100, "A");
      settle();
      chk("A_rd_cnt", 128'(rd_addr_q.size() - rr), 128'd4);
      for (int i = 0; i < 4; i++) chk("A_rd_addr", 128'(rd_addr_q[rr+i]), 128'(i));
      chk("A_beats", 128'(beat_idx_q.size() - br), 128'd3);
      for (int i = 0; i < 3; i++) begin
         chk("A_idx",  128'(beat_idx_q[br+i]), 128'(i+1));
         chk("A_data", 128'(beat_data_q[br+i]), 128'(word(i+1)));
         chk("A_last", 128'(beat_last_q[br+i]), 128'(i == 2));
         chk("A_b2b",  128'(beat_cyc_q[br+i] - beat_cyc_q[br]), 128'(i));
      end
      chk("A_posx",     128'(pos_x(beat_data_q[br])), 128'h1000_0001);
      chk("A_latency",  128'(beat_cyc_q[br] - rd_cyc_q[rr+1]), 128'd3);
      chk("A_done_lat", 128'(done_cyc - beat_cyc_q[br+2]), 128'd1);
      chk("A_done_cnt", 128'(done_cnt - dc), 128'd1);
      chk("A_count",    128'(cell_count), 128'd3);
      chk("A_err",      128'(err_overflow), 128'd0);
      chk("A_busy_end", 128'(busy), 128'd0);

      // B: header=0
      mem_arr[0] = 96'd0;
      br = beat_idx_q.size(); rr = rd_addr_q.size(); vc = valid_cnt;
      pulse_start();
      run_to_done(0, 50, "B");
      @(negedge clock);
      chk("B_busy_after", 128'(busy), 128'd0);
      settle();
      chk("B_rd_cnt",   128'(rd_addr_q.size() - rr), 128'd1);
      chk("B_beats",    128'(beat_idx_q.size() - br), 128'd0);
      chk("B_valid",    128'(valid_cnt - vc), 128'd0);
      chk("B_done_lat", 128'(done_cyc - rd_cyc_q[rr]), 128'd3);
      chk("B_count",    128'(cell_count), 128'd0);

      // C: header=10, ready 1 on / 3 off
      mem_arr[0] = 96'd10;
      br = beat_idx_q.size(); dc = done_cnt;
      pulse_start();
      run_to_done(1, 400, "C");
      settle();
      chk("C_beats", 128'(beat_idx_q.size() - br), 128'd10);
      for (int i = 0; i < 10; i++) begin
         chk("C_idx",  128'(beat_idx_q[br+i]), 128'(i+1));
         chk("C_data", 128'(beat_data_q[br+i]), 128'(word(i+1)));
         chk("C_last", 128'(beat_last_q[br+i]), 128'(i == 9));
      end
      chk("C_done_cnt", 128'(done_cnt - dc), 128'd1);

      // D: header=250 clamps to 219
      mem_arr[0] = 96'd250;
      br = beat_idx_q.size();
      pulse_start();
      run_to_done(0, 1000, "D");
      settle();
      chk("D_count", 128'(cell_count), 128'd219);
      chk("D_err",   128'(err_overflow), 128'd1);
      chk("D_beats", 128'(beat_idx_q.size() - br), 128'd219);
      e = 0;
      for (int i = 0; i < beat_idx_q.size() - br; i++)
         if (beat_idx_q[br+i] !== 8'(i+1) || beat_data_q[br+i] !== word(i+1) ||
             beat_last_q[br+i] !== (i == 218)) e++;
      chk("D_seq_err",  128'(e), 128'd0);
      chk("D_last_idx", 128'(beat_idx_q[beat_idx_q.size()-1]), 128'd219);

      // E: reset with two particle reads in flight, then restart with header=2
      mem_arr[0] = 96'd20;
      pulse_start();
      found = 0;
      for (int k = 0; k < 60 && !found; k++) begin
         @(negedge clock);
         if (bus.mem_rden && bus.mem_address == 8'd4) found = 1;
      end
      chk("E_reached_addr4", 128'(found), 128'd1);
      chk("E_err_cleared",   128'(err_overflow), 128'd0);
      @(posedge clock); #1;
      rst_n = 1'b0;
      #1;
      chk("E_rst_busy",  128'(busy), 128'd0);
      chk("E_rst_valid", 128'(bus.out_valid), 128'd0);
      chk("E_rst_rden",  128'(bus.mem_rden), 128'd0);
      chk("E_rst_count", 128'(cell_count), 128'd0);
      chk("E_rst_addr",  128'(bus.mem_address), 128'd0);
      repeat (3) @(posedge clock); #1;
      rst_n = 1'b1;
      br = beat_idx_q.size(); vc = valid_cnt;
      repeat (10) @(negedge clock);
      #1;
      chk("E_no_beat",  128'(beat_idx_q.size() - br), 128'd0);
      chk("E_no_valid", 128'(valid_cnt - vc), 128'd0);
      mem_arr[0] = 96'd2;
      pulse_start();
      run_to_done(0, 100, "E2");
      settle();
      chk("E2_beats", 128'(beat_idx_q.size() - br), 128'd2);
      chk("E2_idx0",  128'(beat_idx_q[br]), 128'd1);
      chk("E2_idx1",  128'(beat_idx_q[br+1]), 128'd2);
      chk("E2_data1", 128'(beat_data_q[br+1]), 128'(word(2)));

      // F: start during STREAM and on the done cycle is ignored
      mem_arr[0] = 96'd3;
      rr = rd_addr_q.size(); dc = done_cnt; br = beat_idx_q.size();
      pulse_start();
      found = 0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(negedge clock);
         if (bus.mem_rden && bus.mem_address == 8'd2) begin
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
         end
         if (done) begin
            found = 1;
            start = 1'b1;
            @(posedge clock); #1;
            start = 1'b0;
         end
      end
      chk("F_done_seen", 128'(found), 128'd1);
      repeat (10) @(negedge clock);
      #1;
      chk("F_done_cnt", 128'(done_cnt - dc), 128'd1);
      chk("F_rd_cnt",   128'(rd_addr_q.size() - rr), 128'd4);
      chk("F_beats",    128'(beat_idx_q.size() - br), 128'd3);
      chk("F_busy",     128'(busy), 128'd0);

      // Global stream properties
      chk("max_outstanding_le4", 128'(max_out <= 4), 128'd1);
      chk("hold_violations",     128'(hold_err), 128'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
